// File: rtl/prog_loader_pkg.sv
// Shared widths, FSM state encoding and SRAM request bundle for the program loader.
package prog_loader_pkg;

  localparam int D_WIDTH  = 32;
  localparam int SA_WIDTH = 8;
  localparam int SL_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  typedef struct packed {
    logic [SA_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0]  wdata;
    logic                rw;
    logic                en;
  } sram_req_t;

endpackage

// File: rtl/prog_loader_if.sv
// Loader-facing bundle: instruction stream, GPP bus requests, SRAM bus and status.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic                go;
  logic [D_WIDTH-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;
  logic [SA_WIDTH-1:0] gpp_addr;
  logic                gpp_rw;
  logic                gpp_en;
  logic [SA_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0]  mem_wdata;
  logic                mem_rw;
  logic                mem_en;
  logic                str;
  logic                done;
  logic                busy;
  logic                finished;

  modport slave (
    input  go, in_data, in_valid, gpp_addr, gpp_rw, gpp_en, done,
    output in_ready, mem_addr, mem_wdata, mem_rw, mem_en, str, busy, finished
  );

  modport master (
    output go, in_data, in_valid, gpp_addr, gpp_rw, gpp_en, done,
    input  in_ready, mem_addr, mem_wdata, mem_rw, mem_en, str, busy, finished
  );

endinterface

// File: rtl/prog_loader_sram_bus_mux.sv
// SRAM bus owner select: registered loader writes or combinational GPP pass-through.
module sram_bus_mux
  import prog_loader_pkg::*;
(
  input  logic      sel_loader,
  input  sram_req_t loader_req,
  input  sram_req_t gpp_req,
  output sram_req_t mem_req
);

  always_comb begin
    mem_req = gpp_req;
    if (sel_loader) mem_req = loader_req;
  end

endmodule

// File: rtl/prog_loader.sv
// Loads WORDS instruction words into SRAM from address 0, launches the GPP and
// reports its completion; owns the SRAM bus select between loader and core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORDS = SL_WIDTH
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  localparam int CNT_W = $clog2(WORDS + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             start_2nd;
  logic             sel_loader;
  logic             in_ready;
  logic             str;
  logic             busy;
  logic             finished;
  logic             hs_p0;
  sram_req_t        wr_p1;
  sram_req_t        gpp_req;
  sram_req_t        mem_req;

  assign hs_p0 = (state == ST_LOAD) && bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      done_q     <= 1'b0;
      start_2nd  <= 1'b0;
      sel_loader <= 1'b0;
      in_ready   <= 1'b0;
      str        <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      wr_p1      <= '0;
    end else begin
      // done_q tracks Done every cycle so a level held over from START is not an edge
      done_q   <= bus.done;
      wr_p1.en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.go) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            sel_loader <= 1'b1;
          end
        end
        ST_LOAD: begin
          // stage p0 -> p1: accepted word becomes the SRAM write of the next cycle
          if (hs_p0) begin
            wr_p1.addr  <= SA_WIDTH'(cnt);
            wr_p1.wdata <= bus.in_data;
            wr_p1.rw    <= 1'b1;
            wr_p1.en    <= 1'b1;
            cnt         <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WORDS - 1)) begin
              state     <= ST_START;
              in_ready  <= 1'b0;
              str       <= 1'b1;
              start_2nd <= 1'b0;
            end
          end
        end
        ST_START: begin
          if (!start_2nd) begin
            start_2nd <= 1'b1;
          end else begin
            state      <= ST_RUN;
            str        <= 1'b0;
            sel_loader <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.done && !done_q) begin
            state    <= ST_FIN;
            finished <= 1'b1;
          end
        end
        ST_FIN: begin
          state    <= ST_IDLE;
          finished <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gpp_req = '{addr: bus.gpp_addr, wdata: '0, rw: bus.gpp_rw, en: bus.gpp_en};

  sram_bus_mux u_mux (
    .sel_loader (sel_loader),
    .loader_req (wr_p1),
    .gpp_req    (gpp_req),
    .mem_req    (mem_req)
  );

  assign bus.mem_addr  = mem_req.addr;
  assign bus.mem_wdata = mem_req.wdata;
  assign bus.mem_rw    = mem_req.rw;
  assign bus.mem_en    = mem_req.en;
  assign bus.in_ready  = in_ready;
  assign bus.str       = str;
  assign bus.busy      = busy;
  assign bus.finished  = finished;

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and SRAM bus owner that sits directly upstream of the GPP core. On `Go` it accepts a stream of instruction words and writes them to consecutive SRAM addresses starting at 0. It then pulses `Str` to launch the GPP and hands the SRAM bus to the core. When the core raises `Done`, it reports completion. Only one master drives the SRAM at any time: the loader during load, the GPP otherwise.

## Interface
- `WORDS`, default `` `SL_WIDTH ``: number of instruction words loaded per program. Equals the GPP halt PC.
- `Clk`  in  1  system clock, all state changes on its rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Go`  in  1  start request, sampled only in IDLE
- `In_Data`  in  `` `D_WIDTH ``  instruction word
- `In_Valid`  in  1  `In_Data` is valid
- `In_Ready`  out  1  loader accepts `In_Data` this cycle
- `Gpp_Addr`  in  `` `SA_WIDTH ``  GPP address request
- `Gpp_RW`  in  1  GPP read/write request (0 = read)
- `Gpp_En`  in  1  GPP SRAM enable request
- `Mem_Addr`  out  `` `SA_WIDTH ``  SRAM address
- `Mem_Wdata`  out  `` `D_WIDTH ``  SRAM write data
- `Mem_RW`  out  1  SRAM direction (1 = write, 0 = read)
- `Mem_En`  out  1  SRAM enable
- `Str`  out  1  GPP start
- `Done`  in  1  GPP completion flag (level)
- `Busy`  out  1  loader is not IDLE
- `Finished`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, START, RUN, FIN.
- IDLE:
  - `Go` moves to LOAD and clears word count `cnt`.
  - The SRAM bus is in GPP pass-through.
- LOAD:
  - `In_Ready = (cnt < WORDS)`.
  - A handshake occurs when `In_Valid && In_Ready`. On a handshake, the loader registers `Mem_Addr = cnt`, `Mem_Wdata = In_Data`, `Mem_RW = 1`, `Mem_En = 1` for exactly the next cycle, and increments `cnt`.
  - A cycle without a handshake drives `Mem_En = 0` on the following cycle.
  - After the handshake with `cnt == WORDS-1`, the loader goes to START. The final write is on the bus during the first START cycle.
- START:
  - `Str = 1` for exactly 2 cycles. The bus stays with the loader: cycle 1 carries the final write, cycle 2 has `Mem_En = 0`.
  - Then go to RUN.
- RUN:
  - The bus passes `Gpp_Addr`/`Gpp_RW`/`Gpp_En` through combinationally. `Mem_Wdata` = 0.
  - `Done` is registered into `done_q`.
  - A rising edge (`Done && !done_q`) moves to FIN.
  - A `Done` level left over from a previous run does not complete the run.
- FIN: `Finished = 1` for one cycle, then go to IDLE.
- `Go` outside IDLE is ignored.
- `In_Valid` outside LOAD, or when `cnt == WORDS`, is not accepted.
- `cnt` width is `$clog2(WORDS+1)`. The address is `cnt` zero-extended or truncated to `` `SA_WIDTH ``. `WORDS` must be ≤ 2^`` `SA_WIDTH ``.

## Timing
- Reset values, applied while `Rst` is high:
  - State = IDLE; `cnt`, `done_q` = 0.
  - `In_Ready`, `Str`, `Busy`, `Finished` = 0.
  - Registered write fields (`Mem_Addr`/`Mem_Wdata`/`Mem_RW`/`Mem_En`) = 0.
  - Bus select = GPP pass-through.
- Reset mid-LOAD or mid-RUN aborts on the next edge. No partial write is issued after `Rst` is seen.
- Write latency: 1 cycle from handshake to SRAM write. Maximum throughput is one word per cycle.
- `Go` to first `In_Ready`: 1 cycle.
- Last handshake to `Str` rising: 1 cycle.
- `Done` rising to `Finished`: 1 cycle.
- `Busy` = 1 in LOAD, START, RUN and FIN.

## Structure
- `` `D_WIDTH ``, `` `SA_WIDTH `` and `` `SL_WIDTH `` come from the shared `define.h`.
- State encodings are local parameters.
- The bus multiplexer is a natural sub-module, `sram_bus_mux`:
  - select, loader fields and GPP fields in; Mem_* out.
  - Purely combinational.
- The FSM, counter and handshake stay in `prog_loader`.

## Test plan
- `WORDS=4`, `Go`, then words `0x20010005`, `0x20020003`, `0x00221820`, `0x00031080` with `In_Valid` held -> writes to addresses 0..3 on 4 consecutive cycles, then `Str` high 2 cycles, `Busy` = 1.
- `In_Valid` toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0,1,2,3, `Mem_En` = 0 on gap cycles, no duplicate writes.
- Extra `In_Valid` after the 4th word -> `In_Ready` = 0, no 5th write, `Go` during RUN ignored.
- RUN with `Gpp_Addr` = 2, `Gpp_En` = 1 -> `Mem_Addr` = 2, `Mem_RW` = 0, `Mem_En` = 1 in the same cycle. `Done` rises -> `Finished` pulses exactly 1 cycle later, then IDLE.
- `Done` already high on entry to RUN -> no `Finished` until `Done` falls and rises again.
- `Rst` after 2 of 4 words -> next cycle IDLE, `Mem_En` = 0, no further writes. A new `Go` restarts at address 0.
